sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_prio.sv | 26 ++
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the three-port SRAM arbiter.
// The port enum values index the one-hot request, grant and ack vectors.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_LO  = 2'd1,
        ACC_HI  = 2'd2,
        RD_TAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_BOOT  = 2'd0,
        PORT_DATA  = 2'd1,
        PORT_INSTR = 2'd2
    } port_t;

    localparam int NUM_PORTS           = 3;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_SRAM_DATA_WIDTH = 16;
    localparam int DEF_SRAM_ADDR_WIDTH = 10;

endpackage

// File: rtl/sram_arb_prio.sv
// Fixed-priority grant selector: boot only in boot mode, otherwise data over instr.
// A port whose ack is high this cycle is masked so a held level req is not served twice.
module sram_arb_prio
    import sram_arb_pkg::*;
(
    input  logic                 boot_mode,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] ack,
    output logic [NUM_PORTS-1:0] grant
);

    logic [NUM_PORTS-1:0] elig;

    always_comb begin
        elig  = req & ~ack;
        grant = '0;
        if (boot_mode) begin
            grant[PORT_BOOT] = elig[PORT_BOOT];
        end else if (elig[PORT_DATA]) begin
            grant[PORT_DATA] = 1'b1;
        end else if (elig[PORT_INSTR]) begin
            grant[PORT_INSTR] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter sharing one 16-bit synchronous SRAM; each 32-bit access is
// split into a low and a high half-word access driven by a four-state FSM.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
    parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       boot_mode,
    input  logic                       boot_req,
    input  logic [SRAM_ADDR_WIDTH-2:0] boot_addr,
    input  logic [DATA_WIDTH-1:0]      boot_wdata,
    output logic                       boot_ack,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [SRAM_ADDR_WIDTH-2:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_wdata,
    output logic                       data_ack,
    input  logic                       instr_req,
    input  logic [SRAM_ADDR_WIDTH-2:0] instr_addr,
    output logic                       instr_ack,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output state_t                     dbg_state
);

    localparam int WA  = SRAM_ADDR_WIDTH - 1;
    localparam int SDW = SRAM_DATA_WIDTH;

    // Handshake: req is a level held by the requester; ack is a one-cycle pulse
    // marking completion, and the acked port is masked from arbitration that cycle.
    state_t               state;
    port_t                lat_port;
    logic                 lat_we;
    logic [WA-1:0]        lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [NUM_PORTS-1:0] ack_q;

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] grant;
    port_t                g_port;
    logic                 g_we;
    logic [WA-1:0]        g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;

    always_comb begin
        req_vec             = '0;
        req_vec[PORT_BOOT]  = boot_req;
        req_vec[PORT_DATA]  = data_req;
        req_vec[PORT_INSTR] = instr_req;
    end

    sram_arb_prio u_prio (
        .boot_mode (boot_mode),
        .req       (req_vec),
        .ack       (ack_q),
        .grant     (grant)
    );

    always_comb begin
        g_port  = PORT_BOOT;
        g_we    = 1'b1;
        g_addr  = boot_addr;
        g_wdata = boot_wdata;
        if (grant[PORT_DATA]) begin
            g_port  = PORT_DATA;
            g_we    = data_we;
            g_addr  = data_addr;
            g_wdata = data_wdata;
        end else if (grant[PORT_INSTR]) begin
            g_port  = PORT_INSTR;
            g_we    = 1'b0;
            g_addr  = instr_addr;
            g_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_port     <= PORT_BOOT;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            ack_q        <= '0;
            rdata        <= '0;
            sram_ce_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
            sram_lb_n    <= 1'b1;
            sram_addr    <= '0;
            sram_wr_data <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        lat_port     <= g_port;
                        lat_we       <= g_we;
                        lat_addr     <= g_addr;
                        lat_wdata    <= g_wdata;
                        sram_ce_n    <= 1'b0;
                        sram_ub_n    <= 1'b0;
                        sram_lb_n    <= 1'b0;
                        sram_we_n    <= ~g_we;
                        sram_oe_n    <= g_we;
                        sram_addr    <= {g_addr, 1'b0};
                        sram_wr_data <= g_wdata[SDW-1:0];
                        state        <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    sram_addr    <= {lat_addr, 1'b1};
                    sram_wr_data <= lat_wdata[DATA_WIDTH-1:SDW];
                    state        <= ACC_HI;
                end
                ACC_HI: begin
                    sram_ce_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    if (lat_we) begin
                        ack_q[lat_port] <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        // Low half-word was addressed in ACC_LO and is valid now.
                        rdata[SDW-1:0] <= sram_rd_data;
                        state          <= RD_TAIL;
                    end
                end
                RD_TAIL: begin
                    rdata[DATA_WIDTH-1:SDW] <= sram_rd_data;
                    ack_q[lat_port]         <= 1'b1;
                    state                   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign boot_ack  = ack_q[PORT_BOOT];
    assign data_ack  = ack_q[PORT_DATA];
    assign instr_ack = ack_q[PORT_INSTR];
    assign dbg_state = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a synchronous SRAM model and two
// scoreboards: one for SRAM access cycles and one for acks with read data.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam logic [2:0] OH_BOOT  = 3'b001;
    localparam logic [2:0] OH_DATA  = 3'b010;
    localparam logic [2:0] OH_INSTR = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_mode, boot_req, data_req, data_we, instr_req;
    logic [8:0]  boot_addr, data_addr, instr_addr;
    logic [31:0] boot_wdata, data_wdata;
    logic        boot_ack, data_ack, instr_ack;
    logic [31:0] rdata;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wr_data;
    logic [15:0] sram_rd_data = 16'h0;
    state_t      dbg_state;

    logic [15:0] mem    [0:1023];
    logic [15:0] shadow [0:1023];
    logic [66:0] exp_q[$];
    logic [26:0] acc_q[$];
    logic [31:0] model_rdata = 32'h0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    sram_arbiter dut (
        .clk(clk), .rst(rst), .boot_mode(boot_mode),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_ack(boot_ack),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
        .rdata(rdata), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_addr(sram_addr),
        .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: read data appears one cycle after the address
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_wr_data;
        if (!sram_ce_n && !sram_oe_n) sram_rd_data <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_write(input logic [2:0] oh, input logic [8:0] a,
                                       input logic [31:0] d, input int ack_cyc);
        acc_q.push_back({1'b1, a, 1'b0, d[15:0]});
        acc_q.push_back({1'b1, a, 1'b1, d[31:16]});
        shadow[{a, 1'b0}] = d[15:0];
        shadow[{a, 1'b1}] = d[31:16];
        exp_q.push_back({32'(ack_cyc), oh, model_rdata});
    endfunction

    function automatic void push_read(input logic [2:0] oh, input logic [8:0] a, input int ack_cyc);
        acc_q.push_back({1'b0, a, 1'b0, 16'h0});
        acc_q.push_back({1'b0, a, 1'b1, 16'h0});
        model_rdata = {shadow[{a, 1'b1}], shadow[{a, 1'b0}]};
        exp_q.push_back({32'(ack_cyc), oh, model_rdata});
    endfunction

    // Ack scoreboard: cycle of ack, which port, and rdata
    always @(negedge clk) begin : ack_mon
        logic [2:0]  acks;
        logic [66:0] e;
        acks = {instr_ack, data_ack, boot_ack};
        if (acks != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", acks, 3'b000);
            end else begin
                e = exp_q.pop_front();
                check("ack", {32'(cyc), acks, rdata}, e);
            end
        end
    end

    // SRAM access scoreboard: every active cycle must match the next expected access
    always @(negedge clk) begin : acc_mon
        logic [26:0] e;
        logic        w;
        if (!sram_ce_n) begin
            if (acc_q.size() == 0) begin
                check("sram_unexpected", sram_ce_n, 1'b1);
            end else begin
                e = acc_q.pop_front();
                w = e[26];
                check("sram_acc",
                      {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_addr, w ? sram_wr_data : 16'h0},
                      {~w, w, 2'b00, e[25:16], w ? e[15:0] : 16'h0});
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1;
        boot_mode = 1'b0; boot_req = 1'b0; boot_addr = '0; boot_wdata = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        instr_req = 1'b0; instr_addr = '0;

        // Request already pending during reset: served only after release
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h005; data_wdata = 32'h1234ABCD;
        step(2);
        check("reset_state",
              {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_addr, sram_wr_data,
               instr_ack, data_ack, boot_ack, rdata, dbg_state},
              {5'b11111, 10'h0, 16'h0, 3'b000, 32'h0, IDLE});
        rst = 1'b0;
        push_write(OH_DATA, 9'h005, 32'h1234ABCD, cyc + 3);
        step(4);
        data_req = 1'b0;

        // Read back through the instruction port
        instr_req = 1'b1; instr_addr = 9'h005;
        push_read(OH_INSTR, 9'h005, cyc + 4);
        step(5);
        instr_req = 1'b0;
        check("rdata_hold", rdata, 32'h1234ABCD);

        // Top word address: half-words 0x3FE and 0x3FF
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h1FF; data_wdata = 32'h89AB7654;
        push_write(OH_DATA, 9'h1FF, 32'h89AB7654, cyc + 3);
        step(4);
        data_req = 1'b0;

        // Simultaneous data read and instr read: data first, instr back-to-back
        data_req = 1'b1; data_we = 1'b0; data_addr = 9'h1FF;
        instr_req = 1'b1; instr_addr = 9'h005;
        c = cyc;
        push_read(OH_DATA, 9'h1FF, c + 4);
        push_read(OH_INSTR, 9'h005, c + 8);
        step(5);
        check("b2b_acc_lo", dbg_state, ACC_LO);
        data_req = 1'b0;
        step(4);
        instr_req = 1'b0;

        // Data write held through two acks: two transactions, acks four cycles apart
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h020; data_wdata = 32'h0BADCAFE;
        c = cyc;
        push_write(OH_DATA, 9'h020, 32'h0BADCAFE, c + 3);
        push_write(OH_DATA, 9'h020, 32'h0BADCAFE, c + 7);
        step(8);
        data_req = 1'b0;

        // Inputs scrambled and req dropped mid-transaction: latched values complete
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h030; data_wdata = 32'h55AA33CC;
        push_write(OH_DATA, 9'h030, 32'h55AA33CC, cyc + 3);
        step(1);
        data_req = 1'b0; data_we = 1'b0; data_addr = 9'h1AB; data_wdata = 32'hFFFFFFFF;
        step(3);
        instr_req = 1'b1; instr_addr = 9'h030;
        push_read(OH_INSTR, 9'h030, cyc + 4);
        step(5);
        instr_req = 1'b0;

        // Boot mode: only boot writes are served, repeatedly while held
        boot_mode = 1'b1; boot_req = 1'b1; boot_addr = 9'h010; boot_wdata = 32'hCAFEF00D;
        data_req = 1'b1; data_we = 1'b0; data_addr = 9'h005;
        instr_req = 1'b1; instr_addr = 9'h005;
        c = cyc;
        push_write(OH_BOOT, 9'h010, 32'hCAFEF00D, c + 3);
        push_write(OH_BOOT, 9'h010, 32'hCAFEF00D, c + 7);
        push_write(OH_BOOT, 9'h010, 32'hCAFEF00D, c + 11);
        step(12);
        boot_req = 1'b0; data_req = 1'b0; instr_req = 1'b0; boot_mode = 1'b0;

        // Boot request outside boot mode is ignored
        boot_req = 1'b1; boot_addr = 9'h011; boot_wdata = 32'hDEADBEEF;
        step(6);
        check("boot_ignored", dbg_state, IDLE);
        boot_req = 1'b0;
        data_req = 1'b1; data_we = 1'b0; data_addr = 9'h010;
        push_read(OH_DATA, 9'h010, cyc + 4);
        step(5);
        data_req = 1'b0;

        // Mode switch mid-read: read completes, boot served at the next arbitration
        data_req = 1'b1; data_we = 1'b0; data_addr = 9'h1FF;
        c = cyc;
        push_read(OH_DATA, 9'h1FF, c + 4);
        step(1);
        data_req = 1'b0;
        boot_mode = 1'b1; boot_req = 1'b1; boot_addr = 9'h040; boot_wdata = 32'h13579BDF;
        push_write(OH_BOOT, 9'h040, 32'h13579BDF, c + 7);
        step(7);
        boot_req = 1'b0; boot_mode = 1'b0;

        // Reset during ACC_HI of a read: dropped without ack
        data_req = 1'b1; data_we = 1'b0; data_addr = 9'h040;
        acc_q.push_back({1'b0, 9'h040, 1'b0, 16'h0});
        step(2);
        check("pre_rst_state", dbg_state, ACC_HI);
        rst = 1'b1;
        #1;
        check("rst_mid",
              {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_addr, sram_wr_data,
               instr_ack, data_ack, boot_ack, rdata, dbg_state},
              {5'b11111, 10'h0, 16'h0, 3'b000, 32'h0, IDLE});
        data_req = 1'b0;
        model_rdata = 32'h0;
        step(1);
        rst = 1'b0;
        instr_req = 1'b1; instr_addr = 9'h040;
        push_read(OH_INSTR, 9'h040, cyc + 4);
        step(5);
        instr_req = 1'b0;

        step(3);
        check("sb_ack_drain", exp_q.size(), 0);
        check("sb_acc_drain", acc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
